// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared op encodings, FSM state type and default width for the MDU.
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    localparam int c_mdu_width = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } mdu_state_e;

    // Ops 0..3 are the multi-cycle multiply/divide group.
    function automatic logic is_md_op(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_if
// Purpose  : EX-stage <-> MDU handshake and HI/LO bus.
// Revision : 1.0  initial release
// ============================================================================
interface mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, cancel, input stall, done, hi, lo);
    modport slave  (input start, op, a, b, cancel, output stall, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divider
// Purpose  : Unsigned restoring radix-2 divider, one quotient bit per step.
// Revision : 1.0  initial release
// ============================================================================
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Partial remainder shifted left with the next dividend bit; the extra
    // top bit of the trial difference is the borrow that decides restore.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (load) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dvs <= divisor;
        end else if (step) begin
            r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : Multi-cycle MULT/DIV unit with architectural HI/LO registers.
// Revision : 1.0  initial release
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH     = c_mdu_width,
    parameter int DIV_ITERS = c_mdu_width
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    localparam int                 c_cnt_w    = $clog2(DIV_ITERS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV_ITERS - 1);

    mdu_state_e r_state;
    mdu_state_e w_state_nxt;
    logic       w_stall;
    logic       w_done;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_a_neg;
    logic               r_b_neg;
    logic               r_use_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_idle;
    logic               w_accept;
    logic               w_div_op;
    logic               w_signed_op;
    logic               w_div_zero;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_mt_ok;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = w_idle & bus.start & is_md_op(bus.op) & ~bus.cancel;
    assign w_mt_ok     = w_idle & bus.start & ~bus.cancel;
    assign w_div_op    = bus.op[1];
    assign w_signed_op = ~bus.op[0];
    assign w_div_zero  = (bus.b == '0);
    assign w_a_neg     = w_signed_op & bus.a[WIDTH-1];
    assign w_b_neg     = w_signed_op & bus.b[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag     = w_b_neg ? -bus.b : bus.b;

    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    mdu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .step      (r_state == ST_DIV),
        .load      (w_accept & w_div_op),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Quotient sign follows the operand-sign XOR; remainder follows the dividend.
    assign w_fin_lo = r_use_div ? ((r_a_neg ^ r_b_neg) ? -w_quo : w_quo) : r_res_lo;
    assign w_fin_hi = r_use_div ? (r_a_neg ? -w_rem : w_rem) : r_res_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    if (!w_div_op)      w_state_nxt = ST_MUL;
                    else if (w_div_zero) w_state_nxt = ST_FIN;
                    else                 w_state_nxt = ST_DIV;
                end
            end
            ST_MUL: begin
                w_stall     = 1'b1;
                w_state_nxt = ST_FIN;
            end
            ST_DIV: begin
                w_stall = 1'b1;
                if (r_cnt == c_cnt_last) w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.cancel) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_a_neg   <= 1'b0;
            r_b_neg   <= 1'b0;
            r_use_div <= 1'b0;
            r_cnt     <= '0;
            r_res_hi  <= '0;
            r_res_lo  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept) begin
                r_a       <= bus.a;
                r_b       <= bus.b;
                r_signed  <= w_signed_op;
                r_a_neg   <= w_a_neg;
                r_b_neg   <= w_b_neg;
                r_use_div <= w_div_op & ~w_div_zero;
                r_cnt     <= '0;
                if (w_div_op & w_div_zero) begin
                    r_res_hi <= bus.a;
                    r_res_lo <= '1;
                end
            end
            if (r_state == ST_MUL) {r_res_hi, r_res_lo} <= w_prod;
            if (r_state == ST_DIV) r_cnt <= r_cnt + 1'b1;
            if (w_done) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end else if (w_mt_ok && bus.op == OP_MTHI) begin
                r_hi <= bus.a;
            end else if (w_mt_ok && bus.op == OP_MTLO) begin
                r_lo <= bus.a;
            end
        end
    end

    assign bus.stall = w_stall;
    assign bus.done  = w_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Directed self-checking bench for mdu_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   lat;
    int   nst;
    int   nd;

    mdu_if #(.WIDTH(32)) bus ();

    mdu_unit #(.WIDTH(32), .DIV_ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op in the current cycle, then scramble the operand inputs and
    // count cycles until done; lat stays -1 if the budget runs out.
    task automatic issue_and_wait(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input int budget, output int l, output int ns);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        #1;
        l  = -1;
        ns = int'(bus.stall);
        for (int k = 1; k <= budget; k++) begin
            tick();
            bus.start = 1'b0;
            bus.a     = 32'hDEAD_BEEF;
            bus.b     = 32'h0;
            #1;
            if (bus.done) begin
                l = k;
                break;
            end
            ns += int'(bus.stall);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd7;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_done",  64'(bus.done),  64'd0);
        check("rst_hilo",  {bus.hi, bus.lo}, 64'd0);

        // MULT -2 * 3
        issue_and_wait(3'd0, 32'hFFFF_FFFE, 32'd3, 40, lat, nst);
        check("mult_lat",   64'(lat), 64'd2);
        check("mult_stall", 64'(nst), 64'd2);
        check("mult_finst", 64'(bus.stall), 64'd0);
        tick();
        check("mult_res",  {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        check("mult_dn0",  64'(bus.done), 64'd0);

        // MULTU all-ones squared
        issue_and_wait(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, lat, nst);
        tick();
        check("multu_res", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

        // DIVU 100 / 7
        issue_and_wait(3'd3, 32'd100, 32'd7, 40, lat, nst);
        check("divu_lat",   64'(lat), 64'd33);
        check("divu_stall", 64'(nst), 64'd33);
        tick();
        check("divu_res",  {bus.hi, bus.lo}, {32'd2, 32'd14});

        // DIV -7 / 2
        issue_and_wait(3'd2, 32'hFFFF_FFF9, 32'd2, 40, lat, nst);
        check("div_lat", 64'(lat), 64'd33);
        tick();
        check("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV 7 / -2
        issue_and_wait(3'd2, 32'd7, 32'hFFFF_FFFE, 40, lat, nst);
        tick();
        check("div_negb", {bus.hi, bus.lo}, {32'd1, 32'hFFFF_FFFD});

        // DIV overflow case
        issue_and_wait(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 40, lat, nst);
        tick();
        check("div_ovf", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

        // Divide by zero
        issue_and_wait(3'd2, 32'd5, 32'd0, 40, lat, nst);
        check("div0_lat",   64'(lat), 64'd1);
        check("div0_stall", 64'(nst), 64'd1);
        tick();
        check("div0_res", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});

        // MTHI / MTLO
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h11;
        #1;
        check("mthi_stall", 64'(bus.stall), 64'd0);
        tick();
        check("mthi_vis", 64'(bus.hi), 64'h11);
        check("mthi_dn",  64'(bus.done), 64'd0);
        bus.op = 3'd5; bus.a = 32'h22;
        tick();
        bus.start = 1'b0;
        #1;
        check("mtlo_vis", 64'(bus.lo), 64'h22);

        // Cancel mid-divide at N+10
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
        #1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            bus.start = 1'b0;
            if (k == 10) bus.cancel = 1'b1;
            #1;
        end
        check("cancel_dn", 64'(bus.done), 64'd0);
        tick();
        bus.cancel = 1'b0;
        #1;
        check("cancel_idle", 64'(bus.stall), 64'd0);
        check("cancel_dn2",  64'(bus.done),  64'd0);
        check("cancel_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});
        issue_and_wait(3'd1, 32'd3, 32'd4, 40, lat, nst);
        check("cancel_next", 64'(lat), 64'd2);
        tick();
        check("cancel_nres", {bus.hi, bus.lo}, {32'd0, 32'd12});

        // Back-to-back: start held through MULTU, then MTLO
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'h1_0000; bus.b = 32'h1_0000;
        #1;
        nd = int'(bus.done);
        tick(); nd += int'(bus.done);
        tick();
        check("b2b_fin", 64'(bus.done), 64'd1);
        nd += int'(bus.done);
        tick();
        bus.op = 3'd5; bus.a = 32'h5;
        #1;
        nd += int'(bus.done);
        check("b2b_stall", 64'(bus.stall), 64'd0);
        check("b2b_mul",   {bus.hi, bus.lo}, {32'd1, 32'd0});
        tick();
        bus.start = 1'b0;
        #1;
        nd += int'(bus.done);
        check("b2b_mtlo",  {bus.hi, bus.lo}, {32'd1, 32'd5});
        check("b2b_ndone", 64'(nd), 64'd1);

        // Reset at N+5 of a DIV
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd50; bus.b = 32'd3;
        #1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.start = 1'b0;
        end
        rst = 1'b1;
        tick();
        check("mrst_stall", 64'(bus.stall), 64'd0);
        check("mrst_done",  64'(bus.done),  64'd0);
        check("mrst_hilo",  {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;
        issue_and_wait(3'd0, 32'd7, 32'hFFFF_FFFF, 40, lat, nst);
        check("post_lat", 64'(lat), 64'd2);
        tick();
        check("post_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
